// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Signal bundle between the multi-cycle control FSM and the rest of the core
// (instruction register, datapath, instruction/data memories).
//
// Signal names are seen from the controller's side:
//   i_opcode      [OPW]   opcode from IR, stable from DECODE to end of instr
//   i_instr_valid         instruction memory holds a valid word
//   i_mem_ready           data memory completes the current access
//   i_resume              leave HALT
//   o_op          [2]     ALU class (10 move/mem, 01 reg-reg, 00 idle/illegal)
//   o_rdt/o_alusrc/o_mtr  dest-select, immediate-select, mem-to-reg
//   o_mread/o_mwrite      data-memory strobes
//   o_rwrite              register-file write enable
//   o_regprint/o_halted   register dump request / FSM in HALT
//   o_ir_load             latch instruction into IR
//   o_pc_en               advance PC (one pulse per retired/aborted instr)
//   o_illegal             sticky fault flag
//   o_retired     [CNT_W] saturating count of o_pc_en pulses
//
// master : the control FSM      slave : datapath / memories / IR side
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OPW   = 6,
  parameter int CNT_W = 16
);
  logic [OPW-1:0]   i_opcode;
  logic             i_instr_valid;
  logic             i_mem_ready;
  logic             i_resume;
  logic [1:0]       o_op;
  logic             o_rdt;
  logic             o_alusrc;
  logic             o_mtr;
  logic             o_mread;
  logic             o_mwrite;
  logic             o_rwrite;
  logic             o_regprint;
  logic             o_ir_load;
  logic             o_pc_en;
  logic             o_illegal;
  logic             o_halted;
  logic [CNT_W-1:0] o_retired;

  modport master (
    input  i_opcode, i_instr_valid, i_mem_ready, i_resume,
    output o_op, o_rdt, o_alusrc, o_mtr, o_mread, o_mwrite, o_rwrite,
           o_regprint, o_ir_load, o_pc_en, o_illegal, o_halted, o_retired
  );

  modport slave (
    output i_opcode, i_instr_valid, i_mem_ready, i_resume,
    input  o_op, o_rdt, o_alusrc, o_mtr, o_mread, o_mwrite, o_rwrite,
           o_regprint, o_ir_load, o_pc_en, o_illegal, o_halted, o_retired
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control FSM for the 8-bit Harvard core. Sequences
// FETCH/DECODE/EXEC/MEM/WB, stalls on memory handshakes, aborts on illegal
// opcodes and data-memory timeouts, supports HALT/resume and counts retired
// instructions (saturating).
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   multicycle_control_if.master (see interface header for signals)
//
// Parameters:
//   OPW      opcode width (class = top 2 bits, sub-op = remaining bits), >= 5
//   CNT_W    retired counter width
//   MEM_TMO  MEM wait cycles before timeout abort (1..255)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  multicycle_control_if.master   io_bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ILL   = 3'd0,
    K_MVI   = 3'd1,
    K_MOV   = 3'd2,
    K_LOAD  = 3'd3,
    K_STORE = 3'd4,
    K_ALU   = 3'd5,
    K_HLT   = 3'd6
  } kind_t;

  // Last MEM cycle index that may still wait; reaching it without
  // mem_ready aborts the instruction.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  state_t           r_state;
  state_t           w_state_next;
  kind_t            r_kind;
  kind_t            w_kind;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_next;

  logic [1:0]       r_op;
  logic             r_rdt;
  logic             r_alusrc;
  logic             r_mtr;
  logic [1:0]       w_op;
  logic             w_rdt;
  logic             w_alusrc;
  logic             w_mtr;

  logic             r_mread;
  logic             r_mwrite;
  logic             r_rwrite;
  logic             r_pc_en;
  logic             r_halted;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic             w_mread_next;
  logic             w_mwrite_next;
  logic             w_rwrite_next;
  logic             w_pc_en_next;
  logic             w_halted_next;
  logic             w_retire;   // instruction finishes without passing WB
  logic             w_fault;    // illegal opcode or memory timeout

  logic [1:0]       w_cls;
  logic [OPW-3:0]   w_sub;

  assign w_cls = io_bus.i_opcode[OPW-1:OPW-2];
  assign w_sub = io_bus.i_opcode[OPW-3:0];

  // -------------------------------------------------------------------------
  // Opcode classification and decode fields
  // -------------------------------------------------------------------------
  always_comb begin
    w_kind = K_ILL;
    if (&io_bus.i_opcode) begin
      w_kind = K_HLT;
    end else if (w_cls == 2'b01) begin
      w_kind = K_ALU;
    end else if (w_cls == 2'b10 && w_sub[OPW-3:2] == '0) begin
      case (w_sub[1:0])
        2'b00:   w_kind = K_MVI;
        2'b01:   w_kind = K_MOV;
        2'b10:   w_kind = K_LOAD;
        default: w_kind = K_STORE;
      endcase
    end
  end

  always_comb begin
    w_op     = 2'b00;
    w_rdt    = 1'b0;
    w_alusrc = 1'b0;
    w_mtr    = 1'b0;
    case (w_kind)
      K_MVI:   begin w_op = 2'b10; w_alusrc = 1'b1; end
      K_MOV:   w_op = 2'b10;
      K_LOAD:  begin w_op = 2'b10; w_mtr = 1'b1; end
      K_STORE: w_op = 2'b10;
      K_ALU:   begin w_op = 2'b01; w_rdt = 1'b1; end
      default: w_op = 2'b00;
    endcase
  end

  // Decode fields are captured at the end of DECODE and held until the next
  // DECODE, so the datapath sees them steady for the whole instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kind   <= K_ILL;
      r_op     <= 2'b00;
      r_rdt    <= 1'b0;
      r_alusrc <= 1'b0;
      r_mtr    <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_kind   <= w_kind;
      r_op     <= w_op;
      r_rdt    <= w_rdt;
      r_alusrc <= w_alusrc;
      r_mtr    <= w_mtr;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = 8'd0;
    w_retire     = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (io_bus.i_instr_valid) w_state_next = S_DECODE;
      end
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        case (r_kind)
          K_LOAD, K_STORE: w_state_next = S_MEM;
          K_HLT:           w_state_next = S_HALT;
          K_ILL: begin
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
            w_fault      = 1'b1;
          end
          default:         w_state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (io_bus.i_mem_ready) begin
          if (r_kind == K_LOAD) begin
            w_state_next = S_WB;
          end else begin
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
          end
        end else if (r_wait == TMO_LAST) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
          w_fault      = 1'b1;
        end else begin
          w_wait_next  = r_wait + 8'd1;
        end
      end
      S_WB:   w_state_next = S_FETCH;
      S_HALT: begin
        if (io_bus.i_resume) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (values registered on the same edge as the state, so
  // every strobe is high exactly while the FSM sits in the owning state)
  // -------------------------------------------------------------------------
  always_comb begin
    w_mread_next  = (w_state_next == S_MEM) && (r_kind == K_LOAD);
    w_mwrite_next = (w_state_next == S_MEM) && (r_kind == K_STORE);
    w_rwrite_next = (w_state_next == S_WB);
    w_halted_next = (w_state_next == S_HALT);
    // WB retires in WB itself; other completions pulse in the following FETCH
    w_pc_en_next  = (w_state_next == S_WB) || w_retire;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mread   <= 1'b0;
      r_mwrite  <= 1'b0;
      r_rwrite  <= 1'b0;
      r_pc_en   <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_mread   <= w_mread_next;
      r_mwrite  <= w_mwrite_next;
      r_rwrite  <= w_rwrite_next;
      r_pc_en   <= w_pc_en_next;
      r_halted  <= w_halted_next;
      r_illegal <= r_illegal | w_fault;
      if (w_pc_en_next && r_retired != '1) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // IR must capture during FETCH itself, so ir_load follows instr_valid
  // directly; it is gated by reset so all outputs are low while held.
  assign io_bus.o_ir_load  = i_rst_n && (r_state == S_FETCH) && io_bus.i_instr_valid;

  assign io_bus.o_op       = r_op;
  assign io_bus.o_rdt      = r_rdt;
  assign io_bus.o_alusrc   = r_alusrc;
  assign io_bus.o_mtr      = r_mtr;
  assign io_bus.o_mread    = r_mread;
  assign io_bus.o_mwrite   = r_mwrite;
  assign io_bus.o_rwrite   = r_rwrite;
  assign io_bus.o_pc_en    = r_pc_en;
  assign io_bus.o_halted   = r_halted;
  assign io_bus.o_regprint = r_halted;
  assign io_bus.o_illegal  = r_illegal;
  assign io_bus.o_retired  = r_retired;

endmodule
